// File: rtl/store_data_queue.sv
// store_data_queue: in-order store queue handing out wrap-tagged markers at dispatch.
// Stores commit in order from the ROB and drain to data memory one at a time.
module store_data_queue #(
  parameter  int SDQ_ENTRIES  = 16,
  parameter  int RETIRE_WIDTH = 2,
  localparam int PW = $clog2(SDQ_ENTRIES) + 1,
  localparam int CW = $clog2(RETIRE_WIDTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          alloc_valid_i,
  output logic          alloc_ready_o,
  output logic [PW-1:0] alloc_marker_o,
  input  logic          exec_valid_i,
  input  logic [PW-2:0] exec_idx_i,
  input  logic [31:0]   exec_addr_i,
  input  logic [31:0]   exec_data_i,
  input  logic [CW-1:0] commit_count_i,
  input  logic          flush_i,
  output logic          mem_req_valid_o,
  input  logic          mem_req_ready_i,
  output logic [31:0]   mem_req_addr_o,
  output logic [31:0]   mem_req_data_o,
  input  logic          mem_ack_i,
  output logic [PW-1:0] head_marker_o,
  output logic [PW-1:0] count_o,
  output logic          empty_o
);
  // state  | meaning
  // S_IDLE | offering the head store to memory once it is committed and executed
  // S_WAIT | head store issued, waiting for mem_ack_i
  localparam int IW = PW - 1;

  typedef enum logic {S_IDLE, S_WAIT} state_t;
  state_t state_q, state_d;

  logic [PW-1:0] head_q, cmt_q, tail_q, head_d, cmt_d, tail_d;
  logic [PW-1:0] pending, commit_req, commit_n, squash_len;
  logic [SDQ_ENTRIES-1:0] valid_q, addr_valid_q, committed_q, issued_q;
  logic [SDQ_ENTRIES-1:0] valid_d, addr_valid_d, committed_d, issued_d;
  logic [SDQ_ENTRIES-1:0] exec_we, commit_hit, squash_hit;
  logic [31:0] addr_q [SDQ_ENTRIES];
  logic [31:0] data_q [SDQ_ENTRIES];
  logic [IW-1:0] head_idx, tail_idx;
  logic full, do_alloc, req_fire, ack_fire;

  assign head_idx       = head_q[IW-1:0];
  assign tail_idx       = tail_q[IW-1:0];
  assign full           = (head_q[PW-1] != tail_q[PW-1]) && (head_idx == tail_idx);
  assign alloc_ready_o  = ~full;
  assign alloc_marker_o = tail_q;
  assign head_marker_o  = head_q;
  assign count_o        = tail_q - head_q;
  assign empty_o        = (tail_q == head_q);
  assign mem_req_addr_o = addr_q[head_idx];
  assign mem_req_data_o = data_q[head_idx];

  always_comb begin
    state_d         = state_q;
    mem_req_valid_o = 1'b0;
    req_fire        = 1'b0;
    ack_fire        = 1'b0;
    case (state_q)
      S_IDLE: begin
        mem_req_valid_o = valid_q[head_idx] & committed_q[head_idx] &
                          addr_valid_q[head_idx] & ~issued_q[head_idx];
        if (mem_req_valid_o && mem_req_ready_i) begin
          req_fire = 1'b1;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_ack_i) begin
          ack_fire = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Commit saturates at tail; a flush then rewinds tail to the updated commit point.
  always_comb begin
    pending    = tail_q - cmt_q;
    commit_req = PW'(commit_count_i);
    commit_n   = (commit_req > pending) ? pending : commit_req;
    cmt_d      = cmt_q + commit_n;
    do_alloc   = alloc_valid_i && !full && !flush_i;
    tail_d     = flush_i ? cmt_d : tail_q + PW'(do_alloc);
    head_d     = head_q + PW'(ack_fire);
    squash_len = tail_q - cmt_d;
  end

  always_comb begin
    valid_d      = valid_q;
    addr_valid_d = addr_valid_q;
    committed_d  = committed_q;
    issued_d     = issued_q;
    exec_we      = '0;
    commit_hit   = '0;
    squash_hit   = '0;
    for (int i = 0; i < SDQ_ENTRIES; i++) begin
      commit_hit[i] = ({1'b0, IW'(i) - cmt_q[IW-1:0]} < commit_n);
      squash_hit[i] = flush_i && ({1'b0, IW'(i) - cmt_d[IW-1:0]} < squash_len);
      if (exec_valid_i && exec_idx_i == IW'(i) && valid_q[i] && !squash_hit[i]) begin
        addr_valid_d[i] = 1'b1;
        exec_we[i]      = 1'b1;
      end
      if (commit_hit[i]) committed_d[i] = 1'b1;
      if (req_fire && head_idx == IW'(i)) issued_d[i] = 1'b1;
      if ((ack_fire && head_idx == IW'(i)) || squash_hit[i]) begin
        valid_d[i]      = 1'b0;
        addr_valid_d[i] = 1'b0;
        committed_d[i]  = 1'b0;
        issued_d[i]     = 1'b0;
      end
      if (do_alloc && tail_idx == IW'(i)) begin
        valid_d[i]      = 1'b1;
        addr_valid_d[i] = 1'b0;
        committed_d[i]  = 1'b0;
        issued_d[i]     = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      head_q       <= '0;
      cmt_q        <= '0;
      tail_q       <= '0;
      valid_q      <= '0;
      addr_valid_q <= '0;
      committed_q  <= '0;
      issued_q     <= '0;
    end else begin
      state_q      <= state_d;
      head_q       <= head_d;
      cmt_q        <= cmt_d;
      tail_q       <= tail_d;
      valid_q      <= valid_d;
      addr_valid_q <= addr_valid_d;
      committed_q  <= committed_d;
      issued_q     <= issued_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SDQ_ENTRIES; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < SDQ_ENTRIES; i++) begin
        if (exec_we[i]) begin
          addr_q[i] <= exec_addr_i;
          data_q[i] <= exec_data_i;
        end
      end
    end
  end

endmodule

// File: tb/tb_store_data_queue.sv
// Bench for store_data_queue: directed lifecycle scenarios plus a randomized run
// checked against an unbounded-pointer queue model.
module tb_store_data_queue;
  localparam int N  = 16;
  localparam int PW = 5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alloc_valid_i, alloc_ready_o;
  logic [4:0]  alloc_marker_o, head_marker_o, count_o;
  logic        exec_valid_i;
  logic [3:0]  exec_idx_i;
  logic [31:0] exec_addr_i, exec_data_i, mem_req_addr_o, mem_req_data_o;
  logic [1:0]  commit_count_i;
  logic        flush_i, mem_req_valid_o, mem_req_ready_i, mem_ack_i, empty_o;

  int checks = 0;
  int errors = 0;

  // Reference model: pointers count forever, markers are taken mod 32.
  int unsigned m_head, m_cmt, m_tail;
  bit          m_wait;
  bit          m_av [N];
  logic [31:0] m_addr [N];
  logic [31:0] m_data [N];

  store_data_queue #(.SDQ_ENTRIES(16), .RETIRE_WIDTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid_i(alloc_valid_i), .alloc_ready_o(alloc_ready_o), .alloc_marker_o(alloc_marker_o),
    .exec_valid_i(exec_valid_i), .exec_idx_i(exec_idx_i), .exec_addr_i(exec_addr_i), .exec_data_i(exec_data_i),
    .commit_count_i(commit_count_i), .flush_i(flush_i),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_req_addr_o(mem_req_addr_o), .mem_req_data_o(mem_req_data_o), .mem_ack_i(mem_ack_i),
    .head_marker_o(head_marker_o), .count_o(count_o), .empty_o(empty_o)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_head = 0; m_cmt = 0; m_tail = 0; m_wait = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_av[i] = 1'b0; m_addr[i] = '0; m_data[i] = '0;
    end
  endtask

  task automatic model_step();
    int unsigned cnt, n, new_cmt, p;
    bit exec_ok, req_v;
    cnt     = m_tail - m_head;
    req_v   = !m_wait && (m_head < m_cmt) && m_av[m_head % N];
    p       = m_head + ((int'(exec_idx_i) + N - (m_head % N)) % N);
    exec_ok = exec_valid_i && (p < m_tail);
    n       = commit_count_i;
    if (n > m_tail - m_cmt) n = m_tail - m_cmt;
    new_cmt = m_cmt + n;
    if (exec_ok && !(flush_i && p >= new_cmt)) begin
      m_av[exec_idx_i] = 1'b1; m_addr[exec_idx_i] = exec_addr_i; m_data[exec_idx_i] = exec_data_i;
    end
    if (flush_i) begin
      for (int unsigned q = new_cmt; q < m_tail; q++) m_av[q % N] = 1'b0;
      m_tail = new_cmt;
    end else if (alloc_valid_i && cnt < N) begin
      m_av[m_tail % N] = 1'b0;
      m_tail++;
    end
    m_cmt = new_cmt;
    if (req_v && mem_req_ready_i) m_wait = 1'b1;
    else if (m_wait && mem_ack_i) begin m_wait = 1'b0; m_head++; end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic clr_inputs();
    alloc_valid_i = 0; exec_valid_i = 0; exec_idx_i = 0; exec_addr_i = 0; exec_data_i = 0;
    commit_count_i = 0; flush_i = 0; mem_req_ready_i = 0; mem_ack_i = 0;
  endtask

  task automatic reset_dut();
    clr_inputs();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_dut();
    checks++; if (alloc_ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready: got %0h want 1", alloc_ready_o); end
    checks++; if (alloc_marker_o !== 5'd0) begin errors++; $display("FAIL rst_marker: got %0h want 0", alloc_marker_o); end
    checks++; if (mem_req_valid_o !== 1'b0) begin errors++; $display("FAIL rst_req_valid: got %0h want 0", mem_req_valid_o); end
    checks++; if (head_marker_o !== 5'd0) begin errors++; $display("FAIL rst_head: got %0h want 0", head_marker_o); end
    checks++; if (count_o !== 5'd0) begin errors++; $display("FAIL rst_count: got %0h want 0", count_o); end
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL rst_empty: got %0h want 1", empty_o); end
    checks++; if (mem_req_addr_o !== 32'd0) begin errors++; $display("FAIL rst_addr: got %0h want 0", mem_req_addr_o); end
    checks++; if (mem_req_data_o !== 32'd0) begin errors++; $display("FAIL rst_data: got %0h want 0", mem_req_data_o); end
  endtask

  task automatic test_fill();
    reset_dut();
    for (int i = 0; i < N; i++) begin
      checks++; if (alloc_marker_o !== 5'(i)) begin errors++; $display("FAIL fill_marker[%0d]: got %0d want %0d", i, alloc_marker_o, i); end
      alloc_valid_i = 1; tick();
    end
    checks++; if (alloc_ready_o !== 1'b0) begin errors++; $display("FAIL full_ready: got %0h want 0", alloc_ready_o); end
    checks++; if (count_o !== 5'd16) begin errors++; $display("FAIL full_count: got %0d want 16", count_o); end
    tick();
    alloc_valid_i = 0;
    checks++; if (alloc_marker_o !== 5'd16) begin errors++; $display("FAIL full_alloc_ignored: got %0d want 16", alloc_marker_o); end
    checks++; if (count_o !== 5'd16) begin errors++; $display("FAIL full_count2: got %0d want 16", count_o); end
  endtask

  task automatic test_drain_order();
    reset_dut();
    alloc_valid_i = 1; tick(); tick(); alloc_valid_i = 0;
    exec_valid_i = 1; exec_idx_i = 0; exec_addr_i = 32'h100; exec_data_i = 32'hAA; tick();
    exec_idx_i = 1; exec_addr_i = 32'h104; exec_data_i = 32'hBB; tick();
    exec_valid_i = 0; commit_count_i = 2; tick(); commit_count_i = 0;
    checks++; if (mem_req_valid_o !== 1'b1) begin errors++; $display("FAIL drain1_valid: got %0h want 1", mem_req_valid_o); end
    checks++; if (mem_req_addr_o !== 32'h100) begin errors++; $display("FAIL drain1_addr: got %0h want 100", mem_req_addr_o); end
    checks++; if (mem_req_data_o !== 32'hAA) begin errors++; $display("FAIL drain1_data: got %0h want aa", mem_req_data_o); end
    mem_req_ready_i = 1; tick(); mem_req_ready_i = 0;
    checks++; if (mem_req_valid_o !== 1'b0) begin errors++; $display("FAIL drain_wait_valid: got %0h want 0", mem_req_valid_o); end
    tick();
    checks++; if (mem_req_valid_o !== 1'b0) begin errors++; $display("FAIL drain_wait_valid2: got %0h want 0", mem_req_valid_o); end
    mem_ack_i = 1; tick(); mem_ack_i = 0;
    checks++; if (head_marker_o !== 5'd1) begin errors++; $display("FAIL drain1_head: got %0d want 1", head_marker_o); end
    checks++; if (mem_req_valid_o !== 1'b1) begin errors++; $display("FAIL drain2_valid: got %0h want 1", mem_req_valid_o); end
    checks++; if (mem_req_addr_o !== 32'h104) begin errors++; $display("FAIL drain2_addr: got %0h want 104", mem_req_addr_o); end
    checks++; if (mem_req_data_o !== 32'hBB) begin errors++; $display("FAIL drain2_data: got %0h want bb", mem_req_data_o); end
    mem_req_ready_i = 1; tick(); mem_req_ready_i = 0;
    mem_ack_i = 1; tick(); mem_ack_i = 0;
    checks++; if (head_marker_o !== 5'd2) begin errors++; $display("FAIL drain2_head: got %0d want 2", head_marker_o); end
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL drain_empty: got %0h want 1", empty_o); end
  endtask

  task automatic test_flush();
    reset_dut();
    alloc_valid_i = 1; tick(); tick(); tick(); alloc_valid_i = 0;
    exec_valid_i = 1; exec_idx_i = 0; exec_addr_i = 32'h200; exec_data_i = 32'h55; tick(); exec_valid_i = 0;
    commit_count_i = 1; flush_i = 1; tick(); commit_count_i = 0; flush_i = 0;
    checks++; if (alloc_marker_o !== 5'd1) begin errors++; $display("FAIL flush_tail: got %0d want 1", alloc_marker_o); end
    checks++; if (count_o !== 5'd1) begin errors++; $display("FAIL flush_count: got %0d want 1", count_o); end
    checks++; if (mem_req_valid_o !== 1'b1) begin errors++; $display("FAIL flush_survivor_valid: got %0h want 1", mem_req_valid_o); end
    checks++; if (mem_req_addr_o !== 32'h200) begin errors++; $display("FAIL flush_survivor_addr: got %0h want 200", mem_req_addr_o); end
    alloc_valid_i = 1; tick(); alloc_valid_i = 0;
    checks++; if (alloc_marker_o !== 5'd2) begin errors++; $display("FAIL flush_next_marker: got %0d want 2", alloc_marker_o); end
    mem_req_ready_i = 1; tick(); mem_req_ready_i = 0;
    mem_ack_i = 1; tick(); mem_ack_i = 0;
    checks++; if (head_marker_o !== 5'd1) begin errors++; $display("FAIL flush_drain_head: got %0d want 1", head_marker_o); end
    checks++; if (count_o !== 5'd1) begin errors++; $display("FAIL flush_drain_count: got %0d want 1", count_o); end
  endtask

  task automatic test_stall();
    reset_dut();
    alloc_valid_i = 1; tick(); alloc_valid_i = 0;
    exec_valid_i = 1; exec_idx_i = 0; exec_addr_i = 32'h300; exec_data_i = 32'h77; tick(); exec_valid_i = 0;
    commit_count_i = 1; tick(); commit_count_i = 0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (mem_req_valid_o !== 1'b1 || mem_req_addr_o !== 32'h300 || mem_req_data_o !== 32'h77) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got v=%0h a=%0h d=%0h want v=1 a=300 d=77", i, mem_req_valid_o, mem_req_addr_o, mem_req_data_o);
      end
      tick();
    end
    mem_req_ready_i = 1; tick(); mem_req_ready_i = 0;
    tick(); tick();
    checks++; if (head_marker_o !== 5'd0) begin errors++; $display("FAIL stall_head_early: got %0d want 0", head_marker_o); end
    mem_ack_i = 1; tick(); mem_ack_i = 0;
    checks++; if (head_marker_o !== 5'd1) begin errors++; $display("FAIL stall_head_ack: got %0d want 1", head_marker_o); end
    checks++; if (mem_req_valid_o !== 1'b0) begin errors++; $display("FAIL stall_after_ack_valid: got %0h want 0", mem_req_valid_o); end
  endtask

  task automatic test_random();
    int unsigned cyc, span, p;
    bit seen_full;
    reset_dut();
    seen_full = 1'b0;
    for (cyc = 0; cyc < 4000 && m_head < 40; cyc++) begin
      if (m_tail - m_head == N) seen_full = 1'b1;
      checks++;
      if (count_o !== 5'((m_tail - m_head) % 32) || alloc_ready_o !== (m_tail - m_head < N) ||
          empty_o !== (m_tail == m_head) || alloc_marker_o !== 5'(m_tail % 32) || head_marker_o !== 5'(m_head % 32)) begin
        errors++;
        $display("FAIL rand_ptrs cyc %0d: got cnt=%0d rdy=%0h emp=%0h tail=%0d head=%0d want cnt=%0d tail=%0d head=%0d",
                 cyc, count_o, alloc_ready_o, empty_o, alloc_marker_o, head_marker_o,
                 m_tail - m_head, m_tail % 32, m_head % 32);
      end
      checks++;
      if (mem_req_valid_o !== (!m_wait && m_head < m_cmt && m_av[m_head % N])) begin
        errors++; $display("FAIL rand_req_valid cyc %0d: got %0h", cyc, mem_req_valid_o);
      end else if (mem_req_valid_o && (mem_req_addr_o !== m_addr[m_head % N] || mem_req_data_o !== m_data[m_head % N])) begin
        errors++;
        $display("FAIL rand_req_payload cyc %0d: got %0h/%0h want %0h/%0h", cyc, mem_req_addr_o, mem_req_data_o,
                 m_addr[m_head % N], m_data[m_head % N]);
      end
      alloc_valid_i   = ((cyc / 100) % 2 == 0) ? ($urandom_range(7) != 0) : ($urandom_range(3) == 0);
      span            = m_tail - m_head;
      p               = (span != 0) ? m_head + $urandom_range(span - 1) : $urandom_range(N - 1);
      exec_valid_i    = $urandom_range(1);
      exec_idx_i      = 4'(p % N);
      exec_addr_i     = $urandom;
      exec_data_i     = $urandom;
      commit_count_i  = 2'($urandom_range(2));
      flush_i         = ($urandom_range(39) == 0);
      mem_req_ready_i = $urandom_range(1);
      mem_ack_i       = ($urandom_range(2) == 0);
      tick();
    end
    clr_inputs();
    checks++; if (m_head < 40) begin errors++; $display("FAIL rand_lifecycles: got %0d drained want 40 (cycle budget expired)", m_head); end
    checks++; if (!seen_full) begin errors++; $display("FAIL rand_full_reached: got 0 want 1"); end
  endtask

  task automatic test_reset_in_wait();
    reset_dut();
    alloc_valid_i = 1; tick(); alloc_valid_i = 0;
    exec_valid_i = 1; exec_idx_i = 0; exec_addr_i = 32'h400; exec_data_i = 32'h99; tick(); exec_valid_i = 0;
    commit_count_i = 1; tick(); commit_count_i = 0;
    mem_req_ready_i = 1; tick(); mem_req_ready_i = 0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks++; if (count_o !== 5'd0 || empty_o !== 1'b1 || alloc_ready_o !== 1'b1) begin
      errors++; $display("FAIL rstw_occupancy: got cnt=%0d emp=%0h rdy=%0h want 0/1/1", count_o, empty_o, alloc_ready_o); end
    checks++; if (alloc_marker_o !== 5'd0 || head_marker_o !== 5'd0) begin
      errors++; $display("FAIL rstw_markers: got tail=%0d head=%0d want 0/0", alloc_marker_o, head_marker_o); end
    checks++; if (mem_req_valid_o !== 1'b0 || mem_req_addr_o !== 32'd0 || mem_req_data_o !== 32'd0) begin
      errors++; $display("FAIL rstw_req: got v=%0h a=%0h d=%0h want 0/0/0", mem_req_valid_o, mem_req_addr_o, mem_req_data_o); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    mem_ack_i = 1; tick(); mem_ack_i = 0;
    checks++; if (head_marker_o !== 5'd0 || count_o !== 5'd0) begin
      errors++; $display("FAIL rstw_late_ack: got head=%0d cnt=%0d want 0/0", head_marker_o, count_o); end
  endtask

  initial begin
    rst_n = 1'b0;
    clr_inputs();
    test_reset();
    test_fill();
    test_drain_order();
    test_flush();
    test_stall();
    test_random();
    test_reset_in_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
